// File: rtl/ms_uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry,
// used by both the receiver and the transmitter.
package ms_uart_pkg;
    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;
endpackage

// File: rtl/ms_uart_baud_tick.sv
// Oversampling tick generator: one tick every prescale+1 clk cycles while enabled.
// The divider value is captured on wrap/clear, so a new prescale applies at the next wrap.
module ms_uart_baud_tick (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] prescale,
    input  logic        clr,
    output logic        tick
);
    logic [15:0] cnt;
    logic [15:0] prescale_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            prescale_q <= '0;
        end else if (!en || clr) begin
            cnt        <= '0;
            prescale_q <= prescale;
        end else if (cnt == prescale_q) begin
            cnt        <= '0;
            prescale_q <= prescale;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    assign tick = en && !clr && (cnt == prescale_q);
endmodule

// File: rtl/ms_uart_rx.sv
// UART receiver, 8N1-style framing with OVERSAMPLE ticks per bit, centre sampling,
// break suppression via the armed flag, and one-cycle result strobes.
module ms_uart_rx
    import ms_uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          prescale,
    input  logic                 en,
    input  logic                 rx_en,
    input  logic                 RX,
    input  logic                 fifo_full,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy,
    output uart_state_e          dbg_state
);
    localparam int S_W = $clog2(OVERSAMPLE);
    localparam int B_W = $clog2(DATA_BITS + 1);
    localparam logic [S_W-1:0] S_LAST    = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] HALF_LAST = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [B_W-1:0] B_LAST    = B_W'(DATA_BITS - 1);

    logic rx_m, rx_s;
    logic active, tick, clr;
    uart_state_e state, state_n;
    logic [S_W-1:0] s_cnt, s_cnt_n;
    logic [B_W-1:0] b_cnt, b_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, rdata_n;
    logic armed, armed_n, valid_n, frame_err_n, overrun_err_n;

    assign active = en & rx_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RX;
            rx_s <= rx_m;
        end
    end

    ms_uart_baud_tick u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (active),
        .prescale (prescale),
        .clr      (clr),
        .tick     (tick)
    );

    // valid is a one-cycle push into the downstream FIFO; fifo_full acts as the
    // inverted ready and is sampled only in the stop-bit sample cycle.
    always_comb begin
        state_n       = state;
        s_cnt_n       = s_cnt;
        b_cnt_n       = b_cnt;
        shreg_n       = shreg;
        rdata_n       = rdata;
        armed_n       = armed;
        valid_n       = 1'b0;
        frame_err_n   = 1'b0;
        overrun_err_n = 1'b0;
        clr           = 1'b0;
        if (!active) begin
            state_n = IDLE;
            s_cnt_n = '0;
            b_cnt_n = '0;
            clr     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    clr     = 1'b1;
                    s_cnt_n = '0;
                    b_cnt_n = '0;
                    if (rx_s) armed_n = 1'b1;
                    if (armed && !rx_s) state_n = START;
                end
                START: if (tick) begin
                    if (s_cnt == HALF_LAST) begin
                        s_cnt_n = '0;
                        state_n = rx_s ? IDLE : DATA;
                    end else begin
                        s_cnt_n = s_cnt + S_W'(1);
                    end
                end
                DATA: if (tick) begin
                    if (s_cnt == S_LAST) begin
                        s_cnt_n = '0;
                        shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                        b_cnt_n = b_cnt + B_W'(1);
                        if (b_cnt == B_LAST) begin
                            b_cnt_n = '0;
                            state_n = STOP;
                        end
                    end else begin
                        s_cnt_n = s_cnt + S_W'(1);
                    end
                end
                STOP: if (tick) begin
                    if (s_cnt == S_LAST) begin
                        s_cnt_n = '0;
                        state_n = IDLE;
                        if (!rx_s) begin
                            frame_err_n = 1'b1;
                            armed_n     = 1'b0;
                        end else if (fifo_full) begin
                            overrun_err_n = 1'b1;
                        end else begin
                            valid_n = 1'b1;
                            rdata_n = shreg;
                        end
                    end else begin
                        s_cnt_n = s_cnt + S_W'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            s_cnt       <= '0;
            b_cnt       <= '0;
            shreg       <= '0;
            rdata       <= '0;
            armed       <= 1'b0;
            valid       <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state       <= state_n;
            s_cnt       <= s_cnt_n;
            b_cnt       <= b_cnt_n;
            shreg       <= shreg_n;
            rdata       <= rdata_n;
            armed       <= armed_n;
            valid       <= valid_n;
            frame_err   <= frame_err_n;
            overrun_err <= overrun_err_n;
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;
endmodule

// File: tb/tb_ms_uart_rx.sv
// Directed and randomized frame bench for ms_uart_rx with a frame-level reference model.
module tb_ms_uart_rx;
    import ms_uart_pkg::*;
    localparam int OS = 16;
    localparam int DB = 8;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] prescale = 16'd0;
    logic        en = 1'b1, rx_en = 1'b1, RX = 1'b1, fifo_full = 1'b0;
    logic [DB-1:0] rdata;
    logic        valid, frame_err, overrun_err, busy;
    uart_state_e dbg_state;

    ms_uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prescale    (prescale),
        .en          (en),
        .rx_en       (rx_en),
        .RX          (RX),
        .fifo_full   (fifo_full),
        .rdata       (rdata),
        .valid       (valid),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0, n_fail = 0;
    int n_valid = 0, n_ferr = 0, n_ovr = 0;
    int e_valid = 0, e_ferr = 0, e_ovr = 0;
    logic [DB-1:0] e_rdata = '0;
    int valid_cyc = -1, fall_cyc = 0;
    logic [DB-1:0] got_q[$];
    logic [DB-1:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                n_valid++;
                got_q.push_back(rdata);
                valid_cyc = cyc;
            end
            if (frame_err)   n_ferr++;
            if (overrun_err) n_ovr++;
            if (valid || frame_err || overrun_err) begin
                n_cmp++;
                assert (int'(valid) + int'(frame_err) + int'(overrun_err) == 1)
                else begin
                    n_fail++;
                    $error("FAIL pulse_excl: valid/ferr/ovr=%0b%0b%0b required one-hot", valid, frame_err, overrun_err);
                end
            end
        end
    end

    // ---------------- driver / checker tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v, input int ncyc);
        RX = v;
        wait_cycles(ncyc);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input int ps);
        int bc;
        bc = OS * (ps + 1);
        prescale = 16'(ps);
        fall_cyc = cyc;
        drive_bit(1'b0, bc);
        for (int i = 0; i < DB; i++) drive_bit(d[i], bc);
        drive_bit(stop, bc);
        RX = 1'b1;
    endtask

    // Frame-level reference: stop low beats everything, then fifo_full, else a byte.
    task automatic model_frame(input logic [DB-1:0] d, input logic stop, input logic ff);
        if (!stop) e_ferr++;
        else if (ff) e_ovr++;
        else begin
            e_valid++;
            e_rdata = d;
            exp_q.push_back(d);
        end
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_valid_cnt"}, 32'(n_valid), 32'(e_valid));
        chk({tag, "_ferr_cnt"},  32'(n_ferr),  32'(e_ferr));
        chk({tag, "_ovr_cnt"},   32'(n_ovr),   32'(e_ovr));
        chk({tag, "_rdata"},     32'(rdata),   32'(e_rdata));
    endtask

    task automatic check_sb(input string tag);
        chk({tag, "_sb_size"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_sb_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [DB-1:0] d;
        logic          stop, ff;
        int            ps, lat;

        wait_cycles(3);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_ferr",  32'(frame_err), 32'h0);
        chk("rst_ovr",   32'(overrun_err), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        wait_cycles(5);

        // 0xA5 at prescale 0: latency from RX fall to valid
        send_frame(8'hA5, 1'b1, 0);
        model_frame(8'hA5, 1'b1, 1'b0);
        wait_cycles(32);
        lat = valid_cyc - fall_cyc;
        chk("a5_latency_in_range", 32'(lat >= 152 && lat <= 156), 32'h1);
        check_counts("a5");
        check_sb("a5");

        // back-to-back 0x00 / 0xFF at prescale 3
        send_frame(8'h00, 1'b1, 3);
        model_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 3);
        model_frame(8'hFF, 1'b1, 1'b0);
        wait_cycles(128);
        check_counts("b2b");
        check_sb("b2b");

        // start-bit glitch: 4 ticks low at prescale 0
        prescale = 16'd0;
        drive_bit(1'b0, 4);
        chk("glitch_busy_hi", 32'(busy), 32'h1);
        drive_bit(1'b1, 40);
        chk("glitch_busy_lo", 32'(busy), 32'h0);
        chk("glitch_state", 32'(dbg_state), 32'(IDLE));
        check_counts("glitch");

        // framing error followed by a 40-bit break, then a clean frame
        send_frame(8'h3C, 1'b0, 0);
        model_frame(8'h3C, 1'b0, 1'b0);
        drive_bit(1'b0, 40 * OS);
        chk("break_no_restart", 32'(busy), 32'h0);
        check_counts("break");
        drive_bit(1'b1, 2 * OS);
        send_frame(8'h3C, 1'b1, 0);
        model_frame(8'h3C, 1'b1, 1'b0);
        wait_cycles(32);
        check_counts("after_break");

        // overrun: fifo_full held through the stop sample
        fifo_full = 1'b1;
        send_frame(8'h55, 1'b1, 0);
        fifo_full = 1'b0;
        model_frame(8'h55, 1'b1, 1'b1);
        wait_cycles(32);
        check_counts("overrun");

        // drop rx_en in the middle of data bit 4
        prescale = 16'd1;
        drive_bit(1'b0, 32);
        d = 8'h6B;
        for (int i = 0; i < 4; i++) drive_bit(d[i], 32);
        drive_bit(d[4], 16);
        rx_en = 1'b0;
        wait_cycles(1);
        chk("drop_state", 32'(dbg_state), 32'(IDLE));
        chk("drop_busy", 32'(busy), 32'h0);
        RX = 1'b1;
        wait_cycles(20);
        rx_en = 1'b1;
        wait_cycles(5);
        send_frame(8'h81, 1'b1, 1);
        model_frame(8'h81, 1'b1, 1'b0);
        wait_cycles(64);
        check_counts("reenable");
        check_sb("directed");

        // randomized frames against the model
        for (int k = 0; k < 12; k++) begin
            d    = DB'($urandom_range(0, 255));
            ps   = int'($urandom_range(0, 3));
            stop = ($urandom_range(0, 3) != 0);
            ff   = ($urandom_range(0, 3) == 0);
            fifo_full = ff;
            send_frame(d, stop, ps);
            fifo_full = 1'b0;
            model_frame(d, stop, ff);
            wait_cycles(2 * OS * (ps + 1));
            check_counts("rand");
        end
        check_sb("rand");

        // asynchronous reset in the middle of a frame
        prescale = 16'd0;
        drive_bit(1'b0, OS);
        drive_bit(1'b1, 3 * OS);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_state", 32'(dbg_state), 32'(IDLE));
        chk("midrst_rdata", 32'(rdata), 32'h0);
        e_rdata = '0;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(200);
        check_counts("midrst");
        check_sb("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
